// File: rtl/fault_capture_buf_pkg.sv
// Shared definitions for the fault capture buffer.
// Holds the FSM state encoding (visible on the top-level `state` port) and the
// default data/address widths used by the top module and its RAM.
package fault_capture_buf_pkg;

  localparam int unsigned DEF_DW = 32;
  localparam int unsigned DEF_AW = 10;

  typedef enum logic [2:0] {
    ST_ARMED   = 3'd0,
    ST_POST    = 3'd1,
    ST_FROZEN  = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4
  } state_e;

endpackage

// File: rtl/fault_capture_ram.sv
// Simple dual-port history RAM: DW x 2**AW words.
// Ports:
//   clk           clock
//   we/waddr/wdata  synchronous write port
//   re/raddr      read enable and address
//   rdata         registered read data, valid one cycle after re; holds otherwise
// Contents are not reset.
module fault_capture_ram #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned Depth = 2 ** AW;

  logic [DW-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register only updates on re, so the output holds during backpressure.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fault_capture_buf.sv
// Fault capture history buffer.
// Records qualified samples into a circular buffer while armed, tags the write
// address at which the first fault arrived, freezes on the capture-done pulse
// and then streams the frozen history, oldest sample first, on valid/ready.
// Ports:
//   clk, reset (async, active-high), usr_rst (sync re-arm, same effect as reset)
//   sample_stb/sample_data   sample input, written when npi_enable is high
//   npi_enable               write permit
//   fault_trig               fault event pulse (first one per arm is tagged)
//   cap_done                 freeze pulse
//   rd_start                 readout request (honoured only while frozen)
//   m_data/m_valid/m_ready/m_last  readout stream
//   state, wr_ptr, fault_ptr, stop_ptr, wrapped  status
//   frozen_irq               one-cycle pulse when the buffer freezes
module fault_capture_buf
  import fault_capture_buf_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned AW = DEF_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          usr_rst,
  input  logic          sample_stb,
  input  logic [DW-1:0] sample_data,
  input  logic          npi_enable,
  input  logic          fault_trig,
  input  logic          cap_done,
  input  logic          rd_start,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic [2:0]    state,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] fault_ptr,
  output logic [AW-1:0] stop_ptr,
  output logic          wrapped,
  output logic          frozen_irq
);

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] fault_ptr_q, fault_ptr_d;
  logic [AW-1:0] stop_ptr_q, stop_ptr_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;
  logic          wrapped_q, wrapped_d;
  logic          irq_q, irq_d;

  logic          wr_en;
  logic          rd_en;
  logic [AW:0]   count;
  logic [AW-1:0] oldest;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          is_last;

  // Once wrapped, the whole buffer is valid and the oldest word sits at the
  // freeze point; otherwise history runs from address 0 up to stop_ptr.
  assign count   = wrapped_q ? {1'b1, {AW{1'b0}}} : {1'b0, stop_ptr_q};
  assign oldest  = wrapped_q ? stop_ptr_q : '0;
  assign rd_addr = oldest + rd_idx_q;
  assign is_last = ({1'b0, rd_idx_q} == (count - (AW + 1)'(1)));

  assign wr_en = ((state_q == ST_ARMED) || (state_q == ST_POST)) &&
                 sample_stb && npi_enable && !usr_rst;
  assign rd_en = (state_q == ST_RD_ADDR);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    fault_ptr_d = fault_ptr_q;
    stop_ptr_d  = stop_ptr_q;
    rd_idx_d    = rd_idx_q;
    wrapped_d   = wrapped_q;
    irq_d       = 1'b0;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (&wr_ptr_q) begin
        wrapped_d = 1'b1;
      end
    end

    case (state_q)
      ST_ARMED: begin
        // Pre-increment pointer: a same-cycle write lands at fault_ptr.
        if (fault_trig) begin
          fault_ptr_d = wr_ptr_q;
          state_d     = ST_POST;
        end
        if (cap_done) begin
          stop_ptr_d = wr_ptr_d;
          irq_d      = 1'b1;
          state_d    = ST_FROZEN;
        end
      end
      ST_POST: begin
        if (cap_done) begin
          stop_ptr_d = wr_ptr_d;
          irq_d      = 1'b1;
          state_d    = ST_FROZEN;
        end
      end
      ST_FROZEN: begin
        if (rd_start && (count != '0)) begin
          rd_idx_d = '0;
          state_d  = ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: begin
        state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (m_ready) begin
          if (is_last) begin
            state_d = ST_FROZEN;
          end else begin
            rd_idx_d = rd_idx_q + AW'(1);
            state_d  = ST_RD_ADDR;
          end
        end
      end
      default: begin
        state_d = ST_ARMED;
      end
    endcase

    if (usr_rst) begin
      state_d     = ST_ARMED;
      wr_ptr_d    = '0;
      fault_ptr_d = '0;
      stop_ptr_d  = '0;
      rd_idx_d    = '0;
      wrapped_d   = 1'b0;
      irq_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_ARMED;
      wr_ptr_q    <= '0;
      fault_ptr_q <= '0;
      stop_ptr_q  <= '0;
      rd_idx_q    <= '0;
      wrapped_q   <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fault_ptr_q <= fault_ptr_d;
      stop_ptr_q  <= stop_ptr_d;
      rd_idx_q    <= rd_idx_d;
      wrapped_q   <= wrapped_d;
      irq_q       <= irq_d;
    end
  end

  fault_capture_ram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (sample_data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // The RAM read register is not reset, so gate it to keep m_data at 0 when idle.
  assign m_valid    = (state_q == ST_RD_DATA);
  assign m_data     = m_valid ? rd_data : '0;
  assign m_last     = m_valid && is_last;
  assign state      = state_q;
  assign wr_ptr     = wr_ptr_q;
  assign fault_ptr  = fault_ptr_q;
  assign stop_ptr   = stop_ptr_q;
  assign wrapped    = wrapped_q;
  assign frozen_irq = irq_q;

endmodule

// File: tb/tb_fault_capture_buf.sv
// Self-checking bench for fault_capture_buf (AW=4, 16-word history).
// The reference model keeps the full list of accepted samples since arm; the
// expected readout is simply its last min(N,16) entries, oldest first.
module tb_fault_capture_buf;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          usr_rst = 1'b0;
  logic          sample_stb = 1'b0;
  logic [DW-1:0] sample_data = '0;
  logic          npi_enable = 1'b0;
  logic          fault_trig = 1'b0;
  logic          cap_done = 1'b0;
  logic          rd_start = 1'b0;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic [2:0]    state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] fault_ptr;
  logic [AW-1:0] stop_ptr;
  logic          wrapped;
  logic          frozen_irq;

  fault_capture_buf #(
    .DW (DW),
    .AW (AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .usr_rst     (usr_rst),
    .sample_stb  (sample_stb),
    .sample_data (sample_data),
    .npi_enable  (npi_enable),
    .fault_trig  (fault_trig),
    .cap_done    (cap_done),
    .rd_start    (rd_start),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last),
    .state       (state),
    .wr_ptr      (wr_ptr),
    .fault_ptr   (fault_ptr),
    .stop_ptr    (stop_ptr),
    .wrapped     (wrapped),
    .frozen_irq  (frozen_irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int irq_cnt  = 0;

  always @(negedge clk) if (frozen_irq) irq_cnt++;

  // Reference model state
  int unsigned hist[$];
  int unsigned got[$];
  int          writes;
  int          fptr;
  bit          faulted;

  typedef struct {
    int unsigned nstb;
    int unsigned off_lo;
    int unsigned off_hi;
    int unsigned fault_at;
    int unsigned exp_wr;
    int unsigned exp_fault;
    bit          exp_wrapped;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    hist.delete();
    writes  = 0;
    fptr    = 0;
    faulted = 0;
  endtask

  task automatic rearm(input bit use_async, input string tag);
    if (use_async) begin
      reset = 1'b1;
      #2;
      reset = 1'b0;
    end else begin
      usr_rst = 1'b1;
      tick();
      usr_rst = 1'b0;
    end
    model_clear();
    chk({tag, "_rst_state"}, state, 0);
    chk({tag, "_rst_wr_ptr"}, wr_ptr, 0);
    chk({tag, "_rst_fault_ptr"}, fault_ptr, 0);
    chk({tag, "_rst_stop_ptr"}, stop_ptr, 0);
    chk({tag, "_rst_wrapped"}, wrapped, 0);
    chk({tag, "_rst_valid"}, m_valid, 0);
    chk({tag, "_rst_data"}, m_data, 0);
  endtask

  // One clock of write-side stimulus, mirrored into the model.
  task automatic drive(input bit stb, input bit npi, input bit flt, input bit cap,
                       input int unsigned data);
    sample_stb  = stb;
    npi_enable  = npi;
    fault_trig  = flt;
    cap_done    = cap;
    sample_data = data;
    if (flt && !faulted) begin
      faulted = 1;
      fptr    = writes % DEPTH;
    end
    if (stb && npi) begin
      hist.push_back(data);
      writes++;
    end
    tick();
    sample_stb = 0;
    npi_enable = 0;
    fault_trig = 0;
    cap_done   = 0;
  endtask

  task automatic check_frozen(input int unsigned e_wr, input int unsigned e_fault,
                              input bit e_wrap, input string tag);
    chk({tag, "_state_frozen"}, state, 2);
    chk({tag, "_irq_hi"}, frozen_irq, 1);
    chk({tag, "_wr_ptr"}, wr_ptr, e_wr);
    chk({tag, "_stop_ptr"}, stop_ptr, e_wr);
    chk({tag, "_fault_ptr"}, fault_ptr, e_fault);
    chk({tag, "_wrapped"}, wrapped, e_wrap);
    tick();
    chk({tag, "_irq_lo"}, frozen_irq, 0);
  endtask

  // Accept words until m_last (bounded); got may already hold earlier words.
  task automatic collect(input bit rand_ready, input string tag);
    int unsigned cnt;
    bit done;
    cnt  = (hist.size() < DEPTH) ? hist.size() : DEPTH;
    done = 0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        chk($sformatf("%s_last%0d", tag, got.size()), m_last, got.size() == cnt);
        if (m_last) done = 1;
      end
      tick();
    end
    m_ready = 0;
    chk({tag, "_count"}, got.size(), cnt);
    for (int i = 0; i < got.size() && i < cnt; i++) begin
      chk($sformatf("%s_w%0d", tag, i), got[i], hist[hist.size() - cnt + i]);
    end
    chk({tag, "_end_state"}, state, 2);
  endtask

  task automatic read_stream(input bit rand_ready, input string tag);
    int bad;
    got.delete();
    rd_start = 1;
    tick();
    rd_start = 0;
    if (hist.size() == 0) begin
      bad = 0;
      for (int i = 0; i < 8; i++) begin
        if (m_valid) bad++;
        tick();
      end
      chk({tag, "_empty_valid"}, bad, 0);
      chk({tag, "_empty_state"}, state, 2);
    end else begin
      collect(rand_ready, tag);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!m_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid_seen"}, m_valid, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int irq_base;
    int unsigned len;
    string tag;

    vecs[0] = '{nstb: 5,  off_lo: 0, off_hi: 0, fault_at: 0,  exp_wr: 5, exp_fault: 0,
                exp_wrapped: 0};
    vecs[1] = '{nstb: 20, off_lo: 0, off_hi: 0, fault_at: 12, exp_wr: 4, exp_fault: 11,
                exp_wrapped: 1};
    vecs[2] = '{nstb: 6,  off_lo: 3, off_hi: 4, fault_at: 0,  exp_wr: 4, exp_fault: 0,
                exp_wrapped: 0};
    vecs[3] = '{nstb: 0,  off_lo: 0, off_hi: 0, fault_at: 0,  exp_wr: 0, exp_fault: 0,
                exp_wrapped: 0};
    vecs[4] = '{nstb: 16, off_lo: 0, off_hi: 0, fault_at: 1,  exp_wr: 0, exp_fault: 0,
                exp_wrapped: 1};

    tick();
    tick();

    // Table-driven scenarios
    for (int v = 0; v < 5; v++) begin
      tag = $sformatf("vec%0d", v);
      rearm(v % 2 == 0, tag);
      irq_base = irq_cnt;
      for (int unsigned k = 1; k <= vecs[v].nstb; k++) begin
        drive(1, !(k >= vecs[v].off_lo && k <= vecs[v].off_hi), k == vecs[v].fault_at, 0, k);
      end
      chk({tag, "_pre_state"}, state, (vecs[v].fault_at != 0) ? 1 : 0);
      drive(0, 0, 0, 1, 0);
      check_frozen(vecs[v].exp_wr, vecs[v].exp_fault, vecs[v].exp_wrapped, tag);
      read_stream(0, {tag, "_rd1"});
      read_stream(0, {tag, "_rd2"});
      chk({tag, "_irq_pulses"}, irq_cnt - irq_base, 1);
    end

    // Backpressure on word 2 with a stray rd_start during readout
    rearm(0, "bp");
    for (int unsigned k = 1; k <= 6; k++) drive(1, 1, 0, 0, k);
    drive(0, 0, 0, 1, 0);
    tick();
    got.delete();
    rd_start = 1;
    tick();
    rd_start = 0;
    m_ready  = 1;
    wait_valid("bp_w1");
    got.push_back(m_data);
    tick();
    m_ready = 0;
    wait_valid("bp_w2");
    for (int i = 0; i < 3; i++) begin
      rd_start = (i == 0);
      tick();
      rd_start = 0;
      chk($sformatf("bp_hold_valid%0d", i), m_valid, 1);
      chk($sformatf("bp_hold_data%0d", i), m_data, 2);
      chk($sformatf("bp_hold_state%0d", i), state, 4);
    end
    collect(0, "bp");

    // Synchronous re-arm in RD_DATA while stalled
    rearm(0, "ur");
    for (int unsigned k = 10; k <= 14; k++) drive(1, 1, 0, 0, k);
    drive(0, 0, 0, 1, 0);
    tick();
    rd_start = 1;
    tick();
    rd_start = 0;
    m_ready  = 0;
    wait_valid("ur");
    usr_rst = 1;
    tick();
    usr_rst = 0;
    model_clear();
    chk("ur_valid_drop", m_valid, 0);
    chk("ur_state", state, 0);
    chk("ur_wr_ptr", wr_ptr, 0);
    chk("ur_wrapped", wrapped, 0);
    for (int unsigned k = 7; k <= 9; k++) drive(1, 1, 0, 0, k);
    drive(0, 0, 0, 1, 0);
    check_frozen(3, 0, 0, "ur2");
    read_stream(0, "ur2");

    // Asynchronous reset mid-readout drops m_valid immediately
    rd_start = 1;
    tick();
    rd_start = 0;
    wait_valid("ar");
    reset = 1;
    #1;
    chk("ar_valid_async", m_valid, 0);
    chk("ar_state_async", state, 0);
    #1;
    reset = 0;
    model_clear();
    tick();

    // Randomized rounds against the model
    for (int r = 0; r < 10; r++) begin
      tag = $sformatf("rnd%0d", r);
      rearm(r % 3 == 0, tag);
      irq_base = irq_cnt;
      len = $urandom_range(0, 40);
      for (int unsigned c = 0; c < len; c++) begin
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
              $urandom_range(0, 9) == 0, 0, $urandom);
      end
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1, $urandom);
      check_frozen(writes % DEPTH, faulted ? fptr : 0, writes >= DEPTH, tag);
      // Frozen buffer must ignore writes and late faults
      sample_stb = 1;
      npi_enable = 1;
      fault_trig = 1;
      tick();
      sample_stb = 0;
      npi_enable = 0;
      fault_trig = 0;
      chk({tag, "_frz_wr_ptr"}, wr_ptr, writes % DEPTH);
      chk({tag, "_frz_fault"}, fault_ptr, faulted ? fptr : 0);
      chk({tag, "_frz_state"}, state, 2);
      read_stream(1, tag);
      chk({tag, "_irq_pulses"}, irq_cnt - irq_base, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
